// File: rtl/regdst_sel_skid.sv
// regdst_sel_skid
//   Destination-register select stage for the decode/execute boundary.
//   Picks the write-register address from rt, rd, the link register or zero,
//   and registers it behind a valid/ready handshake backed by a 2-entry skid
//   buffer. Entries leave in strict FIFO order. Nothing is lost or duplicated
//   under downstream stalls; only flush or reset discards entries.
//
//   Optional build macro: REGDST_ZERO_SUPPRESS_EN
//     defined   - an entry whose selected address is 0 stores reg_write = 0
//     undefined - reg_write_in is stored unmodified
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   flush          synchronous discard of all held entries
//   in_valid       upstream offers an instruction
//   in_ready       block can accept (registered)
//   rt, rd         register fields (WIDTH bits)
//   sel            00 rt, 01 rd, 10 LINK_REG, 11 zero
//   reg_write_in   instruction writes the register file
//   out_valid      out_addr/out_reg_write hold a valid entry
//   out_ready      downstream accepts this cycle
//   out_addr       selected destination address
//   out_reg_write  registered reg_write for the entry

module regdst_sel_skid #(
  parameter int WIDTH    = 5,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] rd,
  input  logic [1:0]       sel,
  input  logic             reg_write_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_addr,
  output logic             out_reg_write
);

  localparam logic [WIDTH-1:0] LINK_ADDR = WIDTH'(LINK_REG);

  // entry selected from the current inputs; only stored on acceptance
  logic [WIDTH-1:0] addr_nxt;
  logic             rw_nxt;

  // storage
  logic             out_valid_q, skid_valid_q, in_ready_q;
  logic [WIDTH-1:0] out_addr_q, skid_addr_q;
  logic             out_rw_q, skid_rw_q;

  // next-state values for the traffic case (no reset, no flush)
  logic             out_valid_d, skid_valid_d;
  logic [WIDTH-1:0] out_addr_d, skid_addr_d;
  logic             out_rw_d, skid_rw_d;

  logic accept, pop;

  always_comb begin
    addr_nxt = '0;
    unique case (sel)
      2'b00:   addr_nxt = rt;
      2'b01:   addr_nxt = rd;
      2'b10:   addr_nxt = LINK_ADDR;
      default: addr_nxt = '0;
    endcase
  end

`ifdef REGDST_ZERO_SUPPRESS_EN
  // writes to register 0 are meaningless; drop them at capture
  assign rw_nxt = reg_write_in & (addr_nxt != '0);
`else
  assign rw_nxt = reg_write_in;
`endif

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_rw_d     = out_rw_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_rw_d    = skid_rw_q;

    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        // older entry in SKID moves up; a new arrival backfills SKID
        out_valid_d  = 1'b1;
        out_addr_d   = skid_addr_q;
        out_rw_d     = skid_rw_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_addr_d = addr_nxt;
          skid_rw_d   = rw_nxt;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_addr_d = addr_nxt;
          out_rw_d   = rw_nxt;
        end
      end
    end else if (accept) begin
      // OUT is stalled; in_ready guaranteed SKID was free
      skid_valid_d = 1'b1;
      skid_addr_d  = addr_nxt;
      skid_rw_d    = rw_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_addr_q   <= '0;
      out_rw_q     <= 1'b0;
      skid_addr_q  <= '0;
      skid_rw_q    <= 1'b0;
    end else if (flush) begin
      // data registers keep stale contents; valid bits gate them
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_rw_q     <= out_rw_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_rw_q    <= skid_rw_d;
      // registered ready: free exactly when SKID will be empty after this edge
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_addr      = out_addr_q;
  assign out_reg_write = out_rw_q;

endmodule
